// File: rtl/sdram_write_arbiter.sv
// Two-requester write arbiter in front of the f2h_sdram1 Avalon-MM write port.
// Requester 0 is the clear engine and requester 1 is the rasterizer. Ownership is
// granted per burst, ties are broken round-robin, and a granted burst always runs
// to completion. Every grant is preceded by one IDLE arbitration cycle.
module sdram_write_arbiter #(
  parameter int ADDR_WIDTH  = 29,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  // requester 0 (clear engine)
  input  logic [ADDR_WIDTH-1:0]     m0_address,
  input  logic [BURST_WIDTH-1:0]    m0_burstcount,
  input  logic [DATA_WIDTH-1:0]     m0_writedata,
  input  logic [DATA_WIDTH/8-1:0]   m0_byteenable,
  input  logic                      m0_write,
  output logic                      m0_waitrequest,
  // requester 1 (rasterizer)
  input  logic [ADDR_WIDTH-1:0]     m1_address,
  input  logic [BURST_WIDTH-1:0]    m1_burstcount,
  input  logic [DATA_WIDTH-1:0]     m1_writedata,
  input  logic [DATA_WIDTH/8-1:0]   m1_byteenable,
  input  logic                      m1_write,
  output logic                      m1_waitrequest,
  // f2h_sdram1 write port
  output logic [ADDR_WIDTH-1:0]     sdram_address,
  output logic [BURST_WIDTH-1:0]    sdram_burstcount,
  output logic [DATA_WIDTH-1:0]     sdram_writedata,
  output logic [DATA_WIDTH/8-1:0]   sdram_byteenable,
  output logic                      sdram_write,
  input  logic                      sdram_waitrequest,
  // status
  output logic [1:0]                grant,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  // Beats still owed after the last accepted one; 0 means the first beat of the
  // current burst has not been accepted yet.
  logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
  // 0 = m0 was granted last, 1 = m1 was granted last.
  logic                   last_grant_q, last_grant_d;

  logic                   own0, own1;
  logic                   accept;
  logic [BURST_WIDTH-1:0] sel_burstcount;
  logic [BURST_WIDTH-1:0] eff_remaining;

  // Reset forces the idle face on the bus even before the state register settles.
  assign own0   = (state_q == OWN0) && !reset;
  assign own1   = (state_q == OWN1) && !reset;
  assign grant  = {own1, own0};
  assign busy   = own0 | own1;
  assign accept = sdram_write & ~sdram_waitrequest;

  // Route the owner straight through to the slave; everyone else is stalled.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    sdram_address    = '0;
    sdram_burstcount = '0;
    sdram_writedata  = '0;
    sdram_byteenable = '0;
    sdram_write      = 1'b0;
    m0_waitrequest   = 1'b1;
    m1_waitrequest   = 1'b1;
    if (own0) begin
      sdram_address    = m0_address;
      sdram_burstcount = m0_burstcount;
      sdram_writedata  = m0_writedata;
      sdram_byteenable = m0_byteenable;
      sdram_write      = m0_write;
      m0_waitrequest   = sdram_waitrequest;
    end else if (own1) begin
      sdram_address    = m1_address;
      sdram_burstcount = m1_burstcount;
      sdram_writedata  = m1_writedata;
      sdram_byteenable = m1_byteenable;
      sdram_write      = m1_write;
      m1_waitrequest   = sdram_waitrequest;
    end
  end

  // Next-state logic: arbitration in IDLE, beat counting while a burst is owned.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    last_grant_d   = last_grant_q;
    sel_burstcount = (state_q == OWN1) ? m1_burstcount : m0_burstcount;
    // Burstcount is only meaningful on the first beat; a zero is a single beat.
    if (cnt_q == '0) begin
      eff_remaining = (sel_burstcount == '0) ? BURST_WIDTH'(1) : sel_burstcount;
    end else begin
      eff_remaining = cnt_q;
    end
    case (state_q)
      IDLE: begin
        if (m0_write && m1_write) begin
          state_d      = last_grant_q ? OWN0 : OWN1;
          last_grant_d = ~last_grant_q;
        end else if (m0_write) begin
          state_d      = OWN0;
          last_grant_d = 1'b0;
        end else if (m1_write) begin
          state_d      = OWN1;
          last_grant_d = 1'b1;
        end
      end
      OWN0, OWN1: begin
        // A dropped write just leaves the counter alone: ownership is kept.
        if (accept) begin
          if (eff_remaining == BURST_WIDTH'(1)) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d   = eff_remaining - BURST_WIDTH'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, beat counter and round-robin pointer registers.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_sdram_write_arbiter.sv
// Self-checking bench for sdram_write_arbiter: directed scenarios followed by a
// randomized phase, all compared cycle by cycle against a burst-level reference model.
module tb_sdram_write_arbiter;

  localparam int AW = 29;
  localparam int DW = 64;
  localparam int BW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    logic [DW-1:0] data;
  } beat_t;

  logic            clock = 1'b0;
  logic            reset;
  logic [AW-1:0]   m0_address, m1_address, sdram_address;
  logic [BW-1:0]   m0_burstcount, m1_burstcount, sdram_burstcount;
  logic [DW-1:0]   m0_writedata, m1_writedata, sdram_writedata;
  logic [DW/8-1:0] m0_byteenable, m1_byteenable, sdram_byteenable;
  logic            m0_write, m1_write, sdram_write;
  logic            m0_waitrequest, m1_waitrequest, sdram_waitrequest;
  logic [1:0]      grant;
  logic            busy;

  sdram_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clock(clock), .reset(reset),
    .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_writedata(m0_writedata),
    .m0_byteenable(m0_byteenable), .m0_write(m0_write), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_writedata(m1_writedata),
    .m1_byteenable(m1_byteenable), .m1_write(m1_write), .m1_waitrequest(m1_waitrequest),
    .sdram_address(sdram_address), .sdram_burstcount(sdram_burstcount),
    .sdram_writedata(sdram_writedata), .sdram_byteenable(sdram_byteenable),
    .sdram_write(sdram_write), .sdram_waitrequest(sdram_waitrequest),
    .grant(grant), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Requester beat queues, accepted-data logs and observed grant sequence.
  beat_t       q0[$], q1[$];
  logic [DW-1:0] exp_log[$], obs_log[$];
  logic [1:0]  gseq[$];
  logic [1:0]  prev_grant = 2'b00;
  int          busy_cycles;
  logic        pause0 = 1'b0, pause1 = 1'b0;
  int          wr_mode = 0;   // 0: never stall, 1: toggle, 2: random

  // Reference model: who owns the port, beats still owed, who won last.
  int m_owner = -1;
  int m_left  = 0;
  int m_lg    = 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int who, input logic [AW-1:0] addr, input logic [BW-1:0] bc);
    int n;
    beat_t b;
    n = (bc == 0) ? 1 : int'(bc);
    for (int i = 0; i < n; i++) begin
      // Address and burstcount on later beats are noise the arbiter must ignore.
      b.addr = (i == 0) ? addr : AW'($urandom);
      b.bc   = (i == 0) ? bc : BW'($urandom);
      b.data = {$urandom, $urandom};
      if (who == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  // One clock: drive, check against the model, advance the model at the edge.
  task automatic cycle();
    logic          e_sw, e_w0, e_w1, e_busy, acc, r;
    logic [1:0]    e_grant;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    logic [BW-1:0] e_bc;
    int            own;
    case (wr_mode)
      0: sdram_waitrequest = 1'b0;
      1: sdram_waitrequest = ~sdram_waitrequest;
      default: sdram_waitrequest = 1'($urandom_range(0, 1));
    endcase
    m0_write = (q0.size() > 0) && !pause0;
    m1_write = (q1.size() > 0) && !pause1;
    if (q0.size() > 0) begin
      m0_address = q0[0].addr; m0_burstcount = q0[0].bc; m0_writedata = q0[0].data;
    end
    if (q1.size() > 0) begin
      m1_address = q1[0].addr; m1_burstcount = q1[0].bc; m1_writedata = q1[0].data;
    end
    m0_byteenable = 8'($urandom);
    m1_byteenable = 8'($urandom);
    #1;
    own = reset ? -1 : m_owner;
    e_sw = 1'b0; e_w0 = 1'b1; e_w1 = 1'b1; e_grant = 2'b00; e_busy = 1'b0;
    e_addr = '0; e_data = '0; e_bc = '0;
    if (own == 0) begin
      e_sw = m0_write; e_w0 = sdram_waitrequest; e_grant = 2'b01; e_busy = 1'b1;
      e_addr = m0_address; e_data = m0_writedata; e_bc = m0_burstcount;
    end else if (own == 1) begin
      e_sw = m1_write; e_w1 = sdram_waitrequest; e_grant = 2'b10; e_busy = 1'b1;
      e_addr = m1_address; e_data = m1_writedata; e_bc = m1_burstcount;
    end
    check("sdram_write", DW'(sdram_write), DW'(e_sw));
    check("m0_waitrequest", DW'(m0_waitrequest), DW'(e_w0));
    check("m1_waitrequest", DW'(m1_waitrequest), DW'(e_w1));
    check("grant", DW'(grant), DW'(e_grant));
    check("busy", DW'(busy), DW'(e_busy));
    if (own != -1) begin
      check("sdram_address", DW'(sdram_address), DW'(e_addr));
      check("sdram_writedata", sdram_writedata, e_data);
      check("sdram_burstcount", DW'(sdram_burstcount), DW'(e_bc));
      check("sdram_byteenable", DW'(sdram_byteenable),
            DW'((own == 0) ? m0_byteenable : m1_byteenable));
      busy_cycles++;
    end
    if (grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(grant);
    prev_grant = grant;
    if (sdram_write && !sdram_waitrequest) obs_log.push_back(sdram_writedata);
    acc = (own != -1) && e_sw && !sdram_waitrequest;
    r = reset;
    @(posedge clock);
    if (r) begin
      m_owner = -1; m_left = 0; m_lg = 1;
    end else if (m_owner == -1) begin
      if (m0_write && m1_write) m_owner = (m_lg == 1) ? 0 : 1;
      else if (m0_write)        m_owner = 0;
      else if (m1_write)        m_owner = 1;
      if (m_owner != -1) m_lg = m_owner;
    end else if (acc) begin
      beat_t b;
      b = (m_owner == 0) ? q0.pop_front() : q1.pop_front();
      exp_log.push_back(b.data);
      if (m_left == 0) m_left = (b.bc == 0) ? 1 : int'(b.bc);
      m_left--;
      if (m_left == 0) m_owner = -1;
    end
    #1;
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_owner != -1) && n < max) begin
      cycle();
      n++;
    end
    check(tag, DW'(q0.size() > 0 || q1.size() > 0 || m_owner != -1), DW'(0));
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_beats"}, DW'(obs_log.size()), DW'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < obs_log.size(); i++)
      check({tag, "_data"}, obs_log[i], exp_log[i]);
    exp_log.delete();
    obs_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  task automatic start_test();
    gseq.delete();
    busy_cycles = 0;
    exp_log.delete();
    obs_log.delete();
  endtask

  initial begin
    int n_exp;
    reset = 1'b1; sdram_waitrequest = 1'b0;
    m0_write = 0; m1_write = 0;
    m0_address = '0; m1_address = '0; m0_burstcount = '0; m1_burstcount = '0;
    m0_writedata = '0; m1_writedata = '0; m0_byteenable = '0; m1_byteenable = '0;

    // Reset state
    do_reset();
    check("reset_grant", DW'(grant), DW'(2'b00));
    check("reset_sdram_write", DW'(sdram_write), DW'(0));

    // Single requester: m0 burst of 4 at 0x100
    start_test();
    push_burst(0, 29'h100, 8'd4);
    drain("single_drain", 50);
    check("single_busy_cycles", DW'(busy_cycles), DW'(4));
    check("single_grants", DW'(gseq.size()), DW'(1));
    if (gseq.size() > 0) check("single_grant0", DW'(gseq[0]), DW'(2'b01));
    compare_logs("single");

    // Tie after reset: m0 first, then m1 after the bubble
    do_reset();
    start_test();
    push_burst(0, 29'h200, 8'd2);
    push_burst(1, 29'h300, 8'd2);
    drain("tie_drain", 50);
    check("tie_grants", DW'(gseq.size()), DW'(2));
    if (gseq.size() > 1) begin
      check("tie_first", DW'(gseq[0]), DW'(2'b01));
      check("tie_second", DW'(gseq[1]), DW'(2'b10));
    end
    check("tie_busy_cycles", DW'(busy_cycles), DW'(4));
    compare_logs("tie");

    // Round-robin with both requesters held continuously
    start_test();
    for (int i = 0; i < 4; i++) begin
      push_burst(0, AW'(32'h1000 + i * 16), 8'd2);
      push_burst(1, AW'(32'h2000 + i * 16), 8'd2);
    end
    drain("rr_drain", 200);
    check("rr_grants", DW'(gseq.size()), DW'(8));
    for (int i = 0; i < gseq.size(); i++)
      check("rr_order", DW'(gseq[i]), DW'((i % 2 == 0) ? 2'b01 : 2'b10));
    compare_logs("rr");

    // Backpressure: m1 burst of 8 with waitrequest toggling
    start_test();
    wr_mode = 1;
    push_burst(1, 29'h400, 8'd8);
    n_exp = q1.size();
    drain("bp_drain", 100);
    wr_mode = 0;
    check("bp_beats", DW'(obs_log.size()), DW'(n_exp));
    compare_logs("bp");

    // burstcount 0 is a single beat
    start_test();
    push_burst(0, 29'h500, 8'd0);
    drain("bc0_drain", 20);
    check("bc0_busy_cycles", DW'(busy_cycles), DW'(1));
    compare_logs("bc0");

    // Owner drops write for 3 cycles mid-burst while m1 waits
    do_reset();
    start_test();
    push_burst(0, 29'h600, 8'd4);
    push_burst(1, 29'h700, 8'd2);
    for (int i = 0; i < 20 && exp_log.size() < 2; i++) cycle();
    check("pause_beats_before", DW'(exp_log.size()), DW'(2));
    pause0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("pause_grant_held", DW'(grant), DW'(2'b01));
      check("pause_m1_wait", DW'(m1_waitrequest), DW'(1));
    end
    pause0 = 1'b0;
    drain("pause_drain", 50);
    check("pause_grants", DW'(gseq.size()), DW'(2));
    compare_logs("pause");

    // Reset pulsed after beat 2 of 4, then a fresh m1 request
    start_test();
    push_burst(0, 29'h800, 8'd4);
    for (int i = 0; i < 20 && exp_log.size() < 2; i++) cycle();
    check("rst_beats_before", DW'(exp_log.size()), DW'(2));
    q0.delete();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_grant", DW'(grant), DW'(2'b00));
    check("rst_sdram_write", DW'(sdram_write), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    gseq.delete();
    push_burst(1, 29'h900, 8'd3);
    drain("rst_drain", 50);
    check("rst_m1_grants", DW'(gseq.size()), DW'(1));
    if (gseq.size() > 0) check("rst_m1_grant", DW'(gseq[0]), DW'(2'b10));
    compare_logs("rst");

    // Randomized traffic with random stalls and write drops
    start_test();
    wr_mode = 2;
    for (int i = 0; i < 400; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0)
        push_burst(0, AW'($urandom), BW'($urandom_range(0, 6)));
      if (q1.size() == 0 && $urandom_range(0, 3) == 0)
        push_burst(1, AW'($urandom), BW'($urandom_range(0, 6)));
      pause0 = ($urandom_range(0, 5) == 0);
      pause1 = ($urandom_range(0, 5) == 0);
      cycle();
    end
    pause0 = 1'b0; pause1 = 1'b0; wr_mode = 0;
    drain("rand_drain", 200);
    compare_logs("rand");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
